baud_rate_gen: RTL and testbench
================================

// Module: baud_rate_gen
// PURPOSE
//  Free-running modulo-N tick generator for the UART. Divides the system clock
//  by BAUDRATE_DIVISOR and emits a one-clock-wide o_tick pulse every N clocks.
//  The pulse is the oversampling strobe (16x baud) shared by the UART rx and tx.
//  It is the only timing source for the UART datapath.
// PARAMETERS
//  BAUDRATE_DIVISOR       163  clocks per tick (50 MHz / (19200*16)); legal >= 2
//  BAUDRATE_DIVISOR_BITS  8    counter width; 2**BITS >= BAUDRATE_DIVISOR
// PORTS
//  i_clk    in   1  system clock, all logic on rising edge
//  i_reset  in   1  asynchronous, active-high reset
//  o_tick   out  1  one-cycle strobe, high once every BAUDRATE_DIVISOR clocks
// BEHAVIOUR
//  - Clocking: one clock (i_clk). Reset: i_reset is asynchronous and active-high.
//  - Counter: count[BAUDRATE_DIVISOR_BITS-1:0], the only state element.
//  - Reset: i_reset=1 forces count=0 immediately, without waiting for a clock
//    edge. It holds count at 0 while asserted.
//  - Reset value of o_tick is 0 (guaranteed because DIVISOR >= 2).
//  - Counting: on each rising edge with i_reset=0:
//      count <= (count == DIVISOR-1) ? 0 : count+1.
//  - Tick decode: o_tick = (count == DIVISOR-1). This is a compare on the
//    registered count, with no extra register stage.
//  - Timing from reset release: o_tick is first high during the cycle after
//    the (DIVISOR-1)th rising edge.
//  - Periodicity: o_tick is then high exactly 1 cycle in every DIVISOR cycles.
//    Duty cycle is 1/DIVISOR and there are no missing or double pulses.
//  - Wrap: count never exceeds DIVISOR-1. States DIVISOR..2**BITS-1 are
//    unreachable. If one is ever entered (e.g. SEU), the next edge returns
//    count to 0.
//  - Reset mid-period: count returns to 0 asynchronously and o_tick drops
//    at once. The period restarts in full after release. No partial tick
//    is ever emitted.
//  - Simultaneous reset and wrap edge: reset dominates.
//  - Arithmetic: unsigned. The increment is BITS wide. The compare constant
//    is sized to BITS.
//  - Elaboration checks:
//      DIVISOR < 2 -> $error.
//      2**BITS < DIVISOR -> $error.
// STRUCTURE
//  - Shared package uart_pkg holds CLK_FREQ, BAUD_RATE and OVERSAMPLE (16).
//    It also holds the derived default divisor CLK_FREQ/(BAUD_RATE*OVERSAMPLE)
//    and its bit width (clog2).
//  - The block itself is a flat single module: one counter always block plus
//    one compare. No sub-module is needed.
//  - A generic mod_m_counter may be factored out and reused if the rx bit
//    counter needs the same structure.
// TESTING
//  Bench setup: DIVISOR=9, BITS=4, i_clk period 2 ns. Run 200 ns after
//  reset sequencing.
//  1 Reset held:
//      i_reset=1 for 10 ns -> o_tick=0 and count=0 throughout.
//  2 First tick:
//      release reset at a clock edge -> o_tick rises after exactly 8 rising
//      edges and stays high for 1 cycle (2 ns).
//  3 Periodicity:
//      free run 200 ns -> tick spacing is exactly 9 cycles (18 ns).
//      That gives 11 ticks in 200 ns, never high on two consecutive cycles.
//  4 Mid-period reset:
//      assert i_reset at count=5 between edges -> o_tick=0 and count=0
//      asynchronously. After release, the next tick is 8 edges later.
//  5 Reset during tick:
//      assert i_reset while o_tick=1 -> o_tick falls without waiting for a
//      clock edge.
//  6 Parameter sweep:
//      DIVISOR=2/BITS=1 -> tick every other cycle.
//      DIVISOR=16/BITS=4 -> tick every 16 cycles; count wraps 15->0 cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants.
// Holds the system clock frequency, the line baud rate and the receive
// oversampling factor. It also holds the default tick divisor and counter
// width derived from those three values.
package uart_pkg;

  localparam int unsigned CLK_FREQ   = 50_000_000;
  localparam int unsigned BAUD_RATE  = 19_200;
  localparam int unsigned OVERSAMPLE = 16;

  // Round to nearest. The exact ratio is 162.76, so the default is 163.
  localparam int unsigned DEFAULT_DIVISOR =
    (CLK_FREQ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DEFAULT_DIVISOR_BITS = $clog2(DEFAULT_DIVISOR);

endpackage

// File: rtl/baud_rate_gen.sv
// Free-running modulo-N tick generator.
// This is the 16x oversampling strobe shared by the UART rx and tx.
// Ports:
//   i_clk    system clock; all logic runs on the rising edge
//   i_reset  asynchronous, active-high reset; clears the counter immediately
//   o_tick   one-cycle strobe, high once every BAUDRATE_DIVISOR clocks
module baud_rate_gen
  import uart_pkg::*;
#(
  parameter int unsigned BAUDRATE_DIVISOR      = DEFAULT_DIVISOR,
  parameter int unsigned BAUDRATE_DIVISOR_BITS = DEFAULT_DIVISOR_BITS
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam logic [BAUDRATE_DIVISOR_BITS-1:0] LAST =
    BAUDRATE_DIVISOR_BITS'(BAUDRATE_DIVISOR - 1);

  if (BAUDRATE_DIVISOR < 2) begin : g_bad_divisor
    $error("baud_rate_gen: BAUDRATE_DIVISOR must be >= 2");
  end

  if ((64'(1) << BAUDRATE_DIVISOR_BITS) < 64'(BAUDRATE_DIVISOR)) begin : g_bad_bits
    $error("baud_rate_gen: BAUDRATE_DIVISOR_BITS too narrow for BAUDRATE_DIVISOR");
  end

  logic [BAUDRATE_DIVISOR_BITS-1:0] count;

  // The wrap test uses >= rather than ==. Any state above LAST can only be
  // reached through an upset, and this returns it to 0 on the next edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count <= '0;
    end else if (count >= LAST) begin
      count <= '0;
    end else begin
      count <= count + BAUDRATE_DIVISOR_BITS'(1);
    end
  end

  assign o_tick = (count == LAST);

endmodule

// File: tb/tb_baud_rate_gen.sv
// Scoreboard bench for baud_rate_gen.
// It runs three instances (divisor 9, 2 and 16) from one clock and one
// randomized reset. The expected tick and count for each cycle come from
// one quantity: the number of rising edges since reset was last released.
module tb_baud_rate_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick9, tick2, tick16;

  always #10 clk = ~clk;

  baud_rate_gen #(.BAUDRATE_DIVISOR(9), .BAUDRATE_DIVISOR_BITS(4)) dut9 (
    .i_clk(clk), .i_reset(rst), .o_tick(tick9)
  );
  baud_rate_gen #(.BAUDRATE_DIVISOR(2), .BAUDRATE_DIVISOR_BITS(1)) dut2 (
    .i_clk(clk), .i_reset(rst), .o_tick(tick2)
  );
  baud_rate_gen #(.BAUDRATE_DIVISOR(16), .BAUDRATE_DIVISOR_BITS(4)) dut16 (
    .i_clk(clk), .i_reset(rst), .o_tick(tick16)
  );

  typedef struct {
    logic        t9;
    logic        t2;
    logic        t16;
    int unsigned c9;
    int unsigned c16;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks    = 0;
  int unsigned n_fail      = 0;
  int unsigned edges       = 0;  // rising edges since reset release
  int unsigned ticks9_seen = 0;
  logic        prev9       = 1'b0;

  // Reference model. A tick appears after every D-th edge past release,
  // starting with edge D-1.
  function automatic exp_t model(input logic r, input int unsigned e);
    exp_t x;
    x.t9  = !r && (e % 9  == 8);
    x.t2  = !r && (e % 2  == 1);
    x.t16 = !r && (e % 16 == 15);
    x.c9  = r ? 0 : e % 9;
    x.c16 = r ? 0 : e % 16;
    return x;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle. After the rising edge, wait half the high phase. Then
  // drive reset for the rest of the cycle, between edges, and queue the
  // outputs expected at the following falling edge. With probe set, the
  // task also checks that the tick is high before reset is asserted and
  // that it drops right after, with no clock edge in between.
  task automatic do_cycle(input logic r, input logic probe = 1'b0);
    @(posedge clk);
    if (rst) edges = 0;
    else     edges++;
    #5;
    if (probe) check("tick_before_async_reset", tick9, 1);
    rst = r;
    if (r) edges = 0;
    if (probe) begin
      #1;
      check("tick_async_fall", tick9, 0);
      check("count_async_clear", dut9.count, 0);
    end
    exp_q.push_back(model(rst, edges));
  endtask

  // Monitor: samples on the falling edge and compares against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tick_div9",  tick9,  e.t9);
        check("tick_div2",  tick2,  e.t2);
        check("tick_div16", tick16, e.t16);
        check("count_div9",  dut9.count,  e.c9);
        check("count_div16", dut16.count, e.c16);
        check("no_double_tick_div9", prev9 & tick9, 0);
        prev9 = tick9;
        if (tick9) ticks9_seen++;
      end
    end
  end

  initial begin
    int unsigned base;

    // Hold reset for 5 cycles.
    repeat (5) do_cycle(1'b1);

    // Release, then free-run 100 cycles. Edges 8, 17, ..., 98 give 11 ticks.
    do_cycle(1'b0);
    base = ticks9_seen;
    repeat (100) do_cycle(1'b0);
    #6;
    check("ticks_in_100_cycles", ticks9_seen - base, 11);

    // Assert reset between edges while count is 5.
    while ((edges + 1) % 9 != 5) do_cycle(1'b0);
    do_cycle(1'b1);
    do_cycle(1'b1);
    repeat (21) do_cycle(1'b0);

    // Assert reset while the tick is high.
    while ((edges + 1) % 9 != 8) do_cycle(1'b0);
    do_cycle(1'b1, 1'b1);
    repeat (41) do_cycle(1'b0);

    // Random reset pulses of 1 to 3 cycles.
    repeat (400) begin
      if ($urandom_range(0, 19) == 0) repeat ($urandom_range(1, 3)) do_cycle(1'b1);
      else do_cycle(1'b0);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
